// File: rtl/ace_pkg.sv
// ACE snoop types shared by the snoop responder and its decode stage.
// Opcodes, CR response bit positions, cache update operations and responder FSM states.
package ace_pkg;

   typedef logic [3:0] arsnoop_t;

   localparam arsnoop_t AC_READ_ONCE             = 4'b0000;
   localparam arsnoop_t AC_READ_SHARED           = 4'b0001;
   localparam arsnoop_t AC_READ_CLEAN            = 4'b0010;
   localparam arsnoop_t AC_READ_NOT_SHARED_DIRTY = 4'b0011;
   localparam arsnoop_t AC_READ_UNIQUE           = 4'b0111;
   localparam arsnoop_t AC_CLEAN_SHARED          = 4'b1000;
   localparam arsnoop_t AC_CLEAN_INVALID         = 4'b1001;
   localparam arsnoop_t AC_MAKE_INVALID          = 4'b1101;
   localparam arsnoop_t AC_DVM_COMPLETE          = 4'b1110;
   localparam arsnoop_t AC_DVM_MESSAGE           = 4'b1111;

   // CR response: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
   typedef logic [4:0] crresp_t;

   localparam int unsigned CR_DATA_TRANSFER = 0;
   localparam int unsigned CR_ERROR         = 1;
   localparam int unsigned CR_PASS_DIRTY    = 2;
   localparam int unsigned CR_IS_SHARED     = 3;
   localparam int unsigned CR_WAS_UNIQUE    = 4;

   typedef enum logic [1:0] {
      UPD_NONE         = 2'd0,
      UPD_CLEAN_SHARED = 2'd1,
      UPD_CLEAN        = 2'd2,
      UPD_INVALIDATE   = 2'd3
   } snoop_upd_e;

   typedef enum logic [2:0] {
      SNP_IDLE,
      SNP_LOOKUP,
      SNP_RESP,
      SNP_DATA,
      SNP_UPDATE
   } snoop_state_e;

   function automatic logic is_dvm(input arsnoop_t snoop);
      return snoop[3:1] == 3'b111;
   endfunction

endpackage

// File: rtl/ace_snoop_decode.sv
// Maps a snoop opcode and the current line state to the CR response and the cache update.
// Purely combinational; no handshake.
module ace_snoop_decode
   import ace_pkg::*;
(
   input  arsnoop_t   snoop,
   input  logic       hit,
   input  logic       dirty,
   input  logic       shared,
   output crresp_t    resp,
   output snoop_upd_e op
);

   always_comb begin
      resp = '0;
      op   = UPD_NONE;
      case (snoop)
         AC_READ_ONCE: begin
            if (hit) begin
               resp[CR_DATA_TRANSFER] = 1'b1;
               resp[CR_IS_SHARED]     = 1'b1;
               resp[CR_WAS_UNIQUE]    = !shared;
            end
         end
         AC_READ_SHARED, AC_READ_CLEAN, AC_READ_NOT_SHARED_DIRTY: begin
            if (hit) begin
               resp[CR_DATA_TRANSFER] = 1'b1;
               resp[CR_PASS_DIRTY]    = dirty;
               resp[CR_IS_SHARED]     = 1'b1;
               resp[CR_WAS_UNIQUE]    = !shared;
               op                     = UPD_CLEAN_SHARED;
            end
         end
         AC_READ_UNIQUE: begin
            if (hit) begin
               resp[CR_DATA_TRANSFER] = 1'b1;
               resp[CR_PASS_DIRTY]    = dirty;
               resp[CR_WAS_UNIQUE]    = !shared;
               op                     = UPD_INVALIDATE;
            end
         end
         AC_CLEAN_SHARED: begin
            if (hit) begin
               resp[CR_DATA_TRANSFER] = dirty;
               resp[CR_PASS_DIRTY]    = dirty;
               resp[CR_IS_SHARED]     = 1'b1;
               op                     = UPD_CLEAN;
            end
         end
         AC_CLEAN_INVALID: begin
            if (hit) begin
               resp[CR_DATA_TRANSFER] = dirty;
               resp[CR_PASS_DIRTY]    = dirty;
               op                     = UPD_INVALIDATE;
            end
         end
         AC_MAKE_INVALID: begin
            if (hit) op = UPD_INVALIDATE;
         end
         AC_DVM_COMPLETE, AC_DVM_MESSAGE: begin
            op = UPD_NONE;
         end
         default: begin
            // unsupported opcodes report Error whatever the line state
            resp[CR_ERROR] = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: one snoop in flight, lookup -> CR -> optional CD line -> optional state update.
// AC ready only in IDLE; CR/CD/update outputs hold until their ready; one read outstanding, one-entry CD buffer.
module ace_snoop_responder
   import ace_pkg::*;
#(
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned LineBeats = 4,
   localparam int unsigned BeatWidth = (LineBeats > 1) ? $clog2(LineBeats) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ac_valid_i,
   output logic                 ac_ready_o,
   input  logic [AddrWidth-1:0] ac_addr_i,
   input  arsnoop_t             ac_snoop_i,
   input  logic [2:0]           ac_prot_i,
   output logic                 cr_valid_o,
   input  logic                 cr_ready_i,
   output crresp_t              cr_resp_o,
   output logic                 cd_valid_o,
   input  logic                 cd_ready_i,
   output logic [DataWidth-1:0] cd_data_o,
   output logic                 cd_last_o,
   output logic                 lookup_req_o,
   input  logic                 lookup_gnt_i,
   output logic [AddrWidth-1:0] lookup_addr_o,
   input  logic                 lookup_hit_i,
   input  logic                 lookup_dirty_i,
   input  logic                 lookup_shared_i,
   output logic                 rd_req_o,
   input  logic                 rd_gnt_i,
   output logic [BeatWidth-1:0] rd_beat_o,
   input  logic                 rd_valid_i,
   input  logic [DataWidth-1:0] rd_data_i,
   output logic                 upd_valid_o,
   input  logic                 upd_ready_i,
   output logic [1:0]           upd_op_o
);

   localparam int unsigned OffsetWidth = $clog2(LineBeats * DataWidth / 8);
   localparam logic [AddrWidth-1:0] AddrMask = {AddrWidth{1'b1}} << OffsetWidth;
   localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(LineBeats - 1);

   snoop_state_e         state_q, state_d;
   logic [AddrWidth-1:0] addr_q;
   arsnoop_t             snoop_q;
   logic                 hit_q, dirty_q, shared_q;
   logic [BeatWidth-1:0] rd_cnt_q, cd_cnt_q;
   logic                 rd_done_q, pend_q;
   logic                 buf_vld_q;
   logic [DataWidth-1:0] buf_dat_q;
   crresp_t              resp;
   snoop_upd_e           op;
   logic                 ac_fire, lookup_fire, rd_fire, cd_fire;
   logic                 prot_unused;

   assign prot_unused = ^ac_prot_i;

   ace_snoop_decode u_decode (
      .snoop  (snoop_q),
      .hit    (hit_q),
      .dirty  (dirty_q),
      .shared (shared_q),
      .resp   (resp),
      .op     (op)
   );

   assign ac_ready_o    = (state_q == SNP_IDLE);
   assign lookup_req_o  = (state_q == SNP_LOOKUP);
   assign cr_valid_o    = (state_q == SNP_RESP);
   assign upd_valid_o   = (state_q == SNP_UPDATE);
   assign lookup_addr_o = addr_q;
   assign cr_resp_o     = resp;
   assign upd_op_o      = op;
   assign rd_beat_o     = rd_cnt_q;
   assign cd_valid_o    = buf_vld_q;
   assign cd_data_o     = buf_dat_q;
   assign cd_last_o     = buf_vld_q && (cd_cnt_q == LastBeat);

   // A read may only be issued when its data is guaranteed a free buffer slot on return.
   assign rd_req_o = (state_q == SNP_DATA) && !rd_done_q && !pend_q &&
                     (!buf_vld_q || cd_ready_i);

   assign ac_fire     = ac_valid_i && ac_ready_o;
   assign lookup_fire = lookup_req_o && lookup_gnt_i;
   assign rd_fire     = rd_req_o && rd_gnt_i;
   assign cd_fire     = cd_valid_o && cd_ready_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         SNP_IDLE: begin
            if (ac_valid_i) state_d = is_dvm(ac_snoop_i) ? SNP_RESP : SNP_LOOKUP;
         end
         SNP_LOOKUP: begin
            if (lookup_gnt_i) state_d = SNP_RESP;
         end
         SNP_RESP: begin
            if (cr_ready_i) begin
               if (resp[CR_DATA_TRANSFER]) state_d = SNP_DATA;
               else if (op != UPD_NONE)    state_d = SNP_UPDATE;
               else                        state_d = SNP_IDLE;
            end
         end
         SNP_DATA: begin
            if (cd_fire && cd_last_o) state_d = (op != UPD_NONE) ? SNP_UPDATE : SNP_IDLE;
         end
         SNP_UPDATE: begin
            if (upd_ready_i) state_d = SNP_IDLE;
         end
         default: state_d = SNP_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= SNP_IDLE;
         addr_q    <= '0;
         snoop_q   <= AC_READ_ONCE;
         hit_q     <= 1'b0;
         dirty_q   <= 1'b0;
         shared_q  <= 1'b0;
         rd_cnt_q  <= '0;
         cd_cnt_q  <= '0;
         rd_done_q <= 1'b0;
         pend_q    <= 1'b0;
         buf_vld_q <= 1'b0;
         buf_dat_q <= '0;
      end else begin
         state_q <= state_d;
         if (ac_fire) begin
            addr_q    <= ac_addr_i & AddrMask;
            snoop_q   <= ac_snoop_i;
            hit_q     <= 1'b0;
            dirty_q   <= 1'b0;
            shared_q  <= 1'b0;
            rd_cnt_q  <= '0;
            cd_cnt_q  <= '0;
            rd_done_q <= 1'b0;
         end
         if (lookup_fire) begin
            hit_q    <= lookup_hit_i;
            dirty_q  <= lookup_dirty_i;
            shared_q <= lookup_shared_i;
         end
         if (rd_fire) begin
            if (rd_cnt_q == LastBeat) rd_done_q <= 1'b1;
            else                      rd_cnt_q  <= rd_cnt_q + BeatWidth'(1);
         end
         // Data may return in the grant cycle itself; only a later return leaves a read pending.
         if (rd_fire && !rd_valid_i) pend_q <= 1'b1;
         else if (rd_valid_i)        pend_q <= 1'b0;
         if (rd_valid_i && state_q == SNP_DATA) begin
            buf_vld_q <= 1'b1;
            buf_dat_q <= rd_data_i;
         end else if (cd_fire) begin
            buf_vld_q <= 1'b0;
         end
         if (cd_fire) cd_cnt_q <= cd_cnt_q + BeatWidth'(1);
      end
   end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: opcode/line-state table plus timing, stall and reset sequences.
module tb_ace_snoop_responder;
   import ace_pkg::*;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int LB = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          ac_valid_i = 1'b0;
   logic          ac_ready_o;
   logic [AW-1:0] ac_addr_i = '0;
   logic [3:0]    ac_snoop_i = '0;
   logic [2:0]    ac_prot_i = 3'b010;
   logic          cr_valid_o;
   logic          cr_ready_i = 1'b0;
   logic [4:0]    cr_resp_o;
   logic          cd_valid_o;
   logic          cd_ready_i = 1'b0;
   logic [DW-1:0] cd_data_o;
   logic          cd_last_o;
   logic          lookup_req_o;
   logic          lookup_gnt_i = 1'b0;
   logic [AW-1:0] lookup_addr_o;
   logic          lookup_hit_i = 1'b0;
   logic          lookup_dirty_i = 1'b0;
   logic          lookup_shared_i = 1'b0;
   logic          rd_req_o;
   logic          rd_gnt_i = 1'b0;
   logic [1:0]    rd_beat_o;
   logic          rd_valid_i;
   logic [DW-1:0] rd_data_i;
   logic          upd_valid_o;
   logic          upd_ready_i = 1'b0;
   logic [1:0]    upd_op_o;

   always #5 clk_i = ~clk_i;

   ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineBeats(LB)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
      .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
      .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
      .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
      .lookup_req_o(lookup_req_o), .lookup_gnt_i(lookup_gnt_i), .lookup_addr_o(lookup_addr_o),
      .lookup_hit_i(lookup_hit_i), .lookup_dirty_i(lookup_dirty_i), .lookup_shared_i(lookup_shared_i),
      .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_beat_o(rd_beat_o),
      .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
      .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_op_o(upd_op_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int t, input logic [1:0] b);
      return {16'hC0DE, t[15:0], 30'd0, b};
   endfunction

   // stimulus controls (written by the initial block only)
   bit stall_mode = 1'b0;
   bit lat_mode   = 1'b0;
   int txn        = 0;

   // read-port model and monitor state (written by the driver process only)
   int          dly_wait = 0;
   logic        dly_vld  = 1'b0;
   logic [63:0] dly_dat  = '0;
   logic [63:0] cd_dat_q[$];
   logic        cd_last_q[$];
   int          n_lookup = 0, n_resp = 0, n_upd = 0, n_upd_cycles = 0;
   logic [4:0]  last_resp = '0;
   logic [1:0]  last_op = '0;
   logic [63:0] lk_addr = '0;
   int          upd_first_ncd = 0;
   int          out_cnt = 0, max_out = 0, resp_unstable = 0;
   bit          crv_hold = 1'b0, upd_hold = 1'b0;
   logic [4:0]  crv_resp = '0;

   assign rd_valid_i = lat_mode ? dly_vld : (rd_req_o && rd_gnt_i);
   assign rd_data_i  = lat_mode ? dly_dat : pat(txn, rd_beat_o);

   always @(negedge clk_i) begin
      int out_now;
      dly_vld = 1'b0;
      if (dly_wait > 0) begin
         dly_wait--;
         if (dly_wait == 0) dly_vld = 1'b1;
      end
      if (stall_mode) begin
         cd_ready_i   = ($urandom_range(0, 3) != 0);
         rd_gnt_i     = ($urandom_range(0, 2) != 0);
         cr_ready_i   = ($urandom_range(0, 1) != 0);
         upd_ready_i  = ($urandom_range(0, 1) != 0);
         lookup_gnt_i = ($urandom_range(0, 2) != 0);
      end else begin
         cd_ready_i   = 1'b1;
         rd_gnt_i     = 1'b1;
         cr_ready_i   = 1'b1;
         upd_ready_i  = 1'b1;
         lookup_gnt_i = 1'b1;
      end
      #1;
      if (!rst_ni) begin
         dly_wait = 0;
         dly_vld  = 1'b0;
         out_cnt  = 0;
         crv_hold = 1'b0;
         upd_hold = 1'b0;
      end else begin
         if (lat_mode && rd_req_o && rd_gnt_i) begin
            dly_dat  = pat(txn, rd_beat_o);
            dly_wait = int'($urandom_range(1, 3));
         end
         if (cd_valid_o && cd_ready_i) begin
            cd_dat_q.push_back(cd_data_o);
            cd_last_q.push_back(cd_last_o);
         end
         if (lookup_req_o && lookup_gnt_i) begin
            n_lookup++;
            lk_addr = lookup_addr_o;
         end
         if (cr_valid_o) begin
            if (crv_hold && cr_resp_o !== crv_resp) resp_unstable++;
            if (cr_ready_i) begin
               n_resp++;
               last_resp = cr_resp_o;
            end
         end
         crv_hold = cr_valid_o && !cr_ready_i;
         crv_resp = cr_resp_o;
         if (upd_valid_o) begin
            n_upd_cycles++;
            if (!upd_hold) upd_first_ncd = cd_dat_q.size();
            if (upd_ready_i) begin
               n_upd++;
               last_op = upd_op_o;
            end
         end
         upd_hold = upd_valid_o && !upd_ready_i;
         out_now = out_cnt + ((rd_req_o && rd_gnt_i) ? 1 : 0);
         if (out_now > max_out) max_out = out_now;
         if (rd_valid_i) out_now--;
         out_cnt = out_now;
      end
   end

   typedef struct {
      string      name;
      logic [3:0] snoop;
      logic       hit, dirty, shared;
      logic [4:0] resp;
      logic [1:0] op;
      int         beats;
      logic       looked;
   } vec_t;

   vec_t vecs[14];

   task automatic do_snoop(input logic [3:0] snoop, input logic [63:0] addr, output bit ok);
      ok = 1'b0;
      @(negedge clk_i);
      ac_valid_i = 1'b1;
      ac_addr_i  = addr;
      ac_snoop_i = snoop;
      for (int k = 0; k < 100; k++) begin
         if (ac_ready_o) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_i);
      end
      @(negedge clk_i);
      ac_valid_i = 1'b0;
      if (ok) begin
         ok = 1'b0;
         for (int k = 0; k < 500; k++) begin
            if (ac_ready_o) begin
               ok = 1'b1;
               break;
            end
            @(negedge clk_i);
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int  base_cd, base_lk, base_resp, base_upd;
      bit  ok;
      logic [63:0] addr;
      base_cd   = cd_dat_q.size();
      base_lk   = n_lookup;
      base_resp = n_resp;
      base_upd  = n_upd;
      txn++;
      addr = 64'h1234_5678_9ABC_DE00 | 64'(txn * 7 + 3);
      lookup_hit_i    = v.hit;
      lookup_dirty_i  = v.dirty;
      lookup_shared_i = v.shared;
      do_snoop(v.snoop, addr, ok);
      check({v.name, " completes"}, 64'(ok), 64'd1);
      check({v.name, " cr_resp"}, 64'(last_resp), 64'(v.resp));
      check({v.name, " cr count"}, 64'(n_resp - base_resp), 64'd1);
      check({v.name, " lookups"}, 64'(n_lookup - base_lk), 64'(v.looked));
      if (v.looked) check({v.name, " lookup_addr"}, lk_addr, addr & ~64'h1F);
      check({v.name, " cd beats"}, 64'(cd_dat_q.size() - base_cd), 64'(v.beats));
      for (int i = 0; i < v.beats && base_cd + i < cd_dat_q.size(); i++) begin
         check($sformatf("%s cd_data[%0d]", v.name, i), cd_dat_q[base_cd + i], pat(txn, 2'(i)));
         check($sformatf("%s cd_last[%0d]", v.name, i), 64'(cd_last_q[base_cd + i]), 64'(i == LB - 1));
      end
      check({v.name, " updates"}, 64'(n_upd - base_upd), 64'(v.op != 2'd0));
      if (v.op != 2'd0) begin
         check({v.name, " upd_op"}, 64'(last_op), 64'(v.op));
         check({v.name, " upd after cd"}, 64'(upd_first_ncd - base_cd), 64'(v.beats));
      end
   endtask

   initial begin
      int base_cd, base_upd, base_updc;
      bit ok;
      vec_t v;

      vecs[0]  = '{"ReadShared hit dirty unique",  4'b0001, 1, 1, 0, 5'b11101, 2'd1, 4, 1};
      vecs[1]  = '{"ReadUnique hit clean shared",  4'b0111, 1, 0, 1, 5'b00001, 2'd3, 4, 1};
      vecs[2]  = '{"CleanInvalid miss",            4'b1001, 0, 1, 0, 5'b00000, 2'd0, 0, 1};
      vecs[3]  = '{"Opcode 0100",                  4'b0100, 1, 1, 0, 5'b00010, 2'd0, 0, 1};
      vecs[4]  = '{"DVM 1111",                     4'b1111, 1, 1, 0, 5'b00000, 2'd0, 0, 0};
      vecs[5]  = '{"ReadOnce hit clean unique",    4'b0000, 1, 0, 0, 5'b11001, 2'd0, 4, 1};
      vecs[6]  = '{"CleanShared hit dirty",        4'b1000, 1, 1, 0, 5'b01101, 2'd2, 4, 1};
      vecs[7]  = '{"CleanInvalid hit dirty",       4'b1001, 1, 1, 1, 5'b00101, 2'd3, 4, 1};
      vecs[8]  = '{"MakeInvalid hit dirty",        4'b1101, 1, 1, 0, 5'b00000, 2'd3, 0, 1};
      vecs[9]  = '{"ReadClean miss",               4'b0010, 0, 0, 0, 5'b00000, 2'd0, 0, 1};
      vecs[10] = '{"ReadNotSharedDirty hit shrd",  4'b0011, 1, 0, 1, 5'b01001, 2'd1, 4, 1};
      vecs[11] = '{"Opcode 1010 miss",             4'b1010, 0, 0, 0, 5'b00010, 2'd0, 0, 1};
      vecs[12] = '{"DVM 1110",                     4'b1110, 1, 0, 0, 5'b00000, 2'd0, 0, 0};
      vecs[13] = '{"CleanShared hit clean",        4'b1000, 1, 0, 0, 5'b01000, 2'd2, 0, 1};

      // reset values
      repeat (3) @(negedge clk_i);
      #2;
      check("reset ac_ready", 64'(ac_ready_o), 64'd1);
      check("reset cr_valid", 64'(cr_valid_o), 64'd0);
      check("reset cd_valid", 64'(cd_valid_o), 64'd0);
      check("reset lookup_req", 64'(lookup_req_o), 64'd0);
      check("reset rd_req", 64'(rd_req_o), 64'd0);
      check("reset rd_beat", 64'(rd_beat_o), 64'd0);
      check("reset upd_valid", 64'(upd_valid_o), 64'd0);
      check("reset cr_resp", 64'(cr_resp_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // cycle timing: AC at T, lookup at T+1, CR at T+2, idle again at T+3
      lookup_hit_i = 1'b0;
      @(negedge clk_i);
      ac_valid_i = 1'b1;
      ac_snoop_i = 4'b1001;
      ac_addr_i  = 64'h0000_0000_0000_1234;
      check("timing ac_ready before", 64'(ac_ready_o), 64'd1);
      @(negedge clk_i);
      ac_valid_i = 1'b0;
      check("timing lookup_req T+1", 64'(lookup_req_o), 64'd1);
      check("timing lookup_addr", lookup_addr_o, 64'h0000_0000_0000_1220);
      @(negedge clk_i);
      check("timing cr_valid T+2", 64'(cr_valid_o), 64'd1);
      check("timing cr_resp T+2", 64'(cr_resp_o), 64'd0);
      @(negedge clk_i);
      check("timing ac_ready T+3", 64'(ac_ready_o), 64'd1);
      check("timing upd_valid T+3", 64'(upd_valid_o), 64'd0);

      for (int i = 0; i < 14; i++) run_vec(vecs[i]);
      check("zero-wait max outstanding", 64'(max_out), 64'd1);

      // random stalls with late read data
      stall_mode = 1'b1;
      lat_mode   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         v = (i % 2 == 0) ? vecs[0] : vecs[1];
         v.name = $sformatf("stall%0d", i);
         run_vec(v);
      end
      check("stall max outstanding", 64'(max_out), 64'd1);
      check("cr_resp stable while stalled", 64'(resp_unstable), 64'd0);
      stall_mode = 1'b0;
      lat_mode   = 1'b0;
      repeat (4) @(negedge clk_i);

      // reset while beat 2 is in flight
      base_cd   = cd_dat_q.size();
      base_upd  = n_upd;
      base_updc = n_upd_cycles;
      txn++;
      lookup_hit_i    = 1'b1;
      lookup_dirty_i  = 1'b0;
      lookup_shared_i = 1'b0;
      @(negedge clk_i);
      ac_valid_i = 1'b1;
      ac_snoop_i = 4'b0111;
      ac_addr_i  = 64'h0000_0000_0000_4000;
      @(negedge clk_i);
      ac_valid_i = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (cd_dat_q.size() - base_cd == 2) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_i);
      end
      check("reach beat 2", 64'(ok), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("midreset ac_ready", 64'(ac_ready_o), 64'd1);
      check("midreset cd_valid", 64'(cd_valid_o), 64'd0);
      check("midreset cd_last", 64'(cd_last_o), 64'd0);
      check("midreset rd_req", 64'(rd_req_o), 64'd0);
      check("midreset rd_beat", 64'(rd_beat_o), 64'd0);
      check("midreset upd_valid", 64'(upd_valid_o), 64'd0);
      check("midreset cr_valid", 64'(cr_valid_o), 64'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      check("midreset no update", 64'(n_upd_cycles - base_updc), 64'd0);
      check("midreset no extra beats", 64'(cd_dat_q.size() - base_cd), 64'd2);
      check("midreset update count", 64'(n_upd - base_upd), 64'd0);
      v = vecs[0];
      v.name = "after reset";
      run_vec(v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
